// File: rtl/labyrinth_pkg.sv
// Shared labyrinth types: move directions, world-map cell codes, ball sequencer states
// and the one-hot direction request decoder.
package labyrinth_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef struct packed {
        logic valid;
        dir_t dir;
    } dir_req_t;

    localparam logic [1:0] MAP_EMPTY = 2'd0;
    localparam logic [1:0] MAP_PATH  = 2'd1;
    localparam logic [1:0] MAP_WALL  = 2'd2;
    localparam logic [1:0] MAP_GOAL  = 2'd3;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SCAN   = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_COMMIT = 2'd3;

    // {x_inc, x_dec, y_inc, y_dec}: anything other than exactly one bit is no request
    function automatic dir_req_t decode_dir(input logic [3:0] req);
        dir_req_t r;
        r.valid = 1'b1;
        r.dir   = DIR_UP;
        case (req)
            4'b1000: r.dir = DIR_RIGHT;
            4'b0100: r.dir = DIR_LEFT;
            4'b0010: r.dir = DIR_DOWN;
            4'b0001: r.dir = DIR_UP;
            default: r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ball_move_ctrl_if.sv
// World-map lookup port: the ball sequencer (master) drives the pixel address and the
// map block (slave) answers with the cell code one cycle later.
interface ball_move_ctrl_if;

    logic [9:0] wrld_col_addr;
    logic [8:0] wrld_row_addr;
    logic [1:0] wrld_loc_info;

    modport master (
        output wrld_col_addr,
        output wrld_row_addr,
        input  wrld_loc_info
    );

    modport slave (
        input  wrld_col_addr,
        input  wrld_row_addr,
        output wrld_loc_info
    );

endinterface

// File: rtl/ball_move_ctrl_update_tick_gen.sv
// Free-running clock-enable divider that paces ball move attempts; tick is high for the
// single cycle in which the counter sits at its terminal count.
module update_tick_gen #(
    parameter int CLK_FREQUENCY_HZ       = 100000000,
    parameter int UPDATE_FREQUENCY_HZ    = 30,
    parameter int CNTR_WIDTH             = 32,
    parameter int SIMULATE               = 0,
    parameter int SIMULATE_FREQUENCY_CNT = 5
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int TOP_INT = (SIMULATE != 0) ? SIMULATE_FREQUENCY_CNT
                                             : CLK_FREQUENCY_HZ / UPDATE_FREQUENCY_HZ - 1;
    localparam logic [CNTR_WIDTH-1:0] TOP_CNT = CNTR_WIDTH'(TOP_INT);

    logic [CNTR_WIDTH-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (cnt == TOP_CNT) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == TOP_CNT);

endmodule

// File: rtl/ball_move_ctrl.sv
// Ball motion sequencer: on each update tick latches one direction, scans the ball's
// leading edge through the world-map port and commits a one-pixel move if no wall is found.
module ball_move_ctrl #(
    parameter int CLK_FREQUENCY_HZ       = 100000000,
    parameter int UPDATE_FREQUENCY_HZ    = 30,
    parameter int CNTR_WIDTH             = 32,
    parameter int SIMULATE               = 0,
    parameter int SIMULATE_FREQUENCY_CNT = 5,
    parameter int INITIAL_X              = 521,
    parameter int INITIAL_Y              = 247,
    parameter int BALL_SIZE              = 15,
    parameter int MAX_X                  = 639,
    parameter int MAX_Y                  = 479
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    x_increment,
    input  logic                    x_decrement,
    input  logic                    y_increment,
    input  logic                    y_decrement,
    ball_move_ctrl_if.master        wrld,
    output logic [9:0]              x_out,
    output logic [8:0]              y_out,
    output logic                    busy,
    output logic                    move_done,
    output logic                    move_blocked,
    output logic                    goal_hit
);

    import labyrinth_pkg::*;

    localparam int SCAN_W = $clog2(BALL_SIZE + 1);
    localparam logic [SCAN_W-1:0] K_LAST = SCAN_W'(BALL_SIZE - 1);

    logic [1:0]        state;
    dir_t              dir;
    logic [SCAN_W-1:0] k;
    logic              valid;
    logic              goal_seen;
    logic              tick;
    dir_req_t          req;
    logic              at_edge;
    logic              datum_live;
    logic [9:0]        scan_col;
    logic [8:0]        scan_row;

    update_tick_gen #(
        .CLK_FREQUENCY_HZ       (CLK_FREQUENCY_HZ),
        .UPDATE_FREQUENCY_HZ    (UPDATE_FREQUENCY_HZ),
        .CNTR_WIDTH             (CNTR_WIDTH),
        .SIMULATE               (SIMULATE),
        .SIMULATE_FREQUENCY_CNT (SIMULATE_FREQUENCY_CNT)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign req = decode_dir({x_increment, x_decrement, y_increment, y_decrement});

    // Widened sums so a ball touching the far edge is caught before any address is formed
    always_comb begin
        at_edge = 1'b0;
        case (req.dir)
            DIR_RIGHT: at_edge = ({1'b0, x_out} + 11'(BALL_SIZE)) > 11'(MAX_X);
            DIR_LEFT:  at_edge = (x_out == 10'd0);
            DIR_DOWN:  at_edge = ({1'b0, y_out} + 10'(BALL_SIZE)) > 10'(MAX_Y);
            default:   at_edge = (y_out == 9'd0);
        endcase
    end

    // Native-width address sums are safe here: the edge pre-check rules out any wrap
    always_comb begin
        scan_col = x_out;
        scan_row = y_out;
        case (dir)
            DIR_RIGHT: begin
                scan_col = x_out + 10'(BALL_SIZE);
                scan_row = y_out + 9'(k);
            end
            DIR_LEFT: begin
                scan_col = x_out - 10'd1;
                scan_row = y_out + 9'(k);
            end
            DIR_DOWN: begin
                scan_col = x_out + 10'(k);
                scan_row = y_out + 9'(BALL_SIZE);
            end
            default: begin
                scan_col = x_out + 10'(k);
                scan_row = y_out - 9'd1;
            end
        endcase
    end

    assign wrld.wrld_col_addr = (state == ST_SCAN) ? scan_col : x_out;
    assign wrld.wrld_row_addr = (state == ST_SCAN) ? scan_row : y_out;

    // Map data lags its address by a cycle, so the first SCAN cycle has nothing to sample
    assign datum_live = ((state == ST_SCAN) && (k != '0)) || (state == ST_DRAIN);
    assign busy       = (state != ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            dir          <= DIR_UP;
            k            <= '0;
            valid        <= 1'b0;
            goal_seen    <= 1'b0;
            x_out        <= 10'(INITIAL_X);
            y_out        <= 9'(INITIAL_Y);
            move_done    <= 1'b0;
            move_blocked <= 1'b0;
            goal_hit     <= 1'b0;
        end else begin
            move_done    <= 1'b0;
            move_blocked <= 1'b0;
            goal_hit     <= 1'b0;

            if (datum_live) begin
                if (wrld.wrld_loc_info == MAP_WALL) valid <= 1'b0;
                if (wrld.wrld_loc_info == MAP_GOAL) goal_seen <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (tick && req.valid) begin
                        dir       <= req.dir;
                        k         <= '0;
                        goal_seen <= 1'b0;
                        valid     <= !at_edge;
                        state     <= at_edge ? ST_COMMIT : ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (k == K_LAST) begin
                        state <= ST_DRAIN;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    state <= ST_COMMIT;
                end
                default: begin
                    if (valid) begin
                        case (dir)
                            DIR_RIGHT: x_out <= x_out + 10'd1;
                            DIR_LEFT:  x_out <= x_out - 10'd1;
                            DIR_DOWN:  y_out <= y_out + 9'd1;
                            default:   y_out <= y_out - 9'd1;
                        endcase
                        move_done <= 1'b1;
                        goal_hit  <= goal_seen;
                    end else begin
                        move_blocked <= 1'b1;
                    end
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
